// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read arbiter: FSM encoding, RRESP and BURST codes.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/rr_priority_picker.sv
// One-hot winner picker. Requests at or above the pointer get first chance.
// If none of them is set, the unmasked copy in the upper half wraps the
// search around to index 0 (masked double-request scheme).
module rr_priority_picker
  import axi_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl_req;
  logic [2*N-1:0] w_dbl_gnt;

  // Lowest set bit of {req, req & mask}; fold both halves back to N bits
  always_comb begin
    w_mask    = ~(({{(N-1){1'b0}}, 1'b1} << i_ptr) - {{(N-1){1'b0}}, 1'b1});
    w_dbl_req = {i_req, i_req & w_mask};
    w_dbl_gnt = w_dbl_req & (~w_dbl_req + {{(2*N-1){1'b0}}, 1'b1});
    o_grant   = w_dbl_gnt[N-1:0] | w_dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port (AR + R) between NUM_MASTERS requesters, one
// whole burst at a time, and checks the R beat count against ARLEN.
// Build option: AXI_RD_ARB_RR_EN selects round-robin arbitration. Without it,
// arbitration is fixed priority (lowest index wins) and no pointer is built.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            s_arvalid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  s_arlen,
  input  logic [NUM_MASTERS*3-1:0]          s_arsize,
  input  logic [NUM_MASTERS*2-1:0]          s_arburst,
  output logic [NUM_MASTERS-1:0]            s_arready,
  output logic [NUM_MASTERS-1:0]            s_rvalid,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  output logic                              s_rlast,
  output logic [1:0]                        s_rresp,
  input  logic [NUM_MASTERS-1:0]            s_rready,
  output logic                              m_arvalid,
  output logic [ADDR_WIDTH-1:0]             m_araddr,
  output logic [LEN_WIDTH-1:0]              m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  input  logic                              m_arready,
  input  logic                              m_rvalid,
  input  logic [DATA_WIDTH-1:0]             m_rdata,
  input  logic                              m_rlast,
  input  logic [1:0]                        m_rresp,
  output logic                              m_rready,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              len_err
);

  localparam int IW = $clog2(NUM_MASTERS);

  arb_state_e             r_state;
  arb_state_e             w_next_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_idx;
  logic [LEN_WIDTH-1:0]   r_len_q;
  logic [LEN_WIDTH:0]     r_beat_cnt;
  logic                   r_len_err;

  logic [NUM_MASTERS-1:0] w_win;
  logic [IW-1:0]          w_win_idx;
  logic [IW-1:0]          w_ptr;
  logic                   w_sel_arvalid;
  logic                   w_ar_hs;
  logic                   w_r_hs;

`ifdef AXI_RD_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  // Round-robin pointer: advance past the owner when its burst completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_r_hs && m_rlast) begin
      r_ptr <= (r_idx == IW'(NUM_MASTERS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .PW (IW)
  ) u_picker (
    .i_req   (s_arvalid),
    .i_ptr   (w_ptr),
    .o_grant (w_win)
  );

  // Encode the one-hot winner so the AR fields can be muxed by index
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_win_idx = w_win_idx | (w_win[i] ? IW'(i) : IW'(0));
    end
  end

  assign w_sel_arvalid = s_arvalid[r_idx];
  assign w_ar_hs       = (r_state == ST_ADDR) && w_sel_arvalid && m_arready;
  assign w_r_hs        = (r_state == ST_DATA) && m_rvalid && m_rready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an owner dropping ARVALID in ADDR abandons the request
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|s_arvalid) w_next_state = ST_ADDR;
        else            w_next_state = ST_IDLE;
      end
      ST_ADDR: begin
        if (w_ar_hs)             w_next_state = ST_DATA;
        else if (!w_sel_arvalid) w_next_state = ST_IDLE;
        else                     w_next_state = ST_ADDR;
      end
      ST_DATA: begin
        if (w_r_hs && m_rlast) w_next_state = ST_IDLE;
        else                   w_next_state = ST_DATA;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Owner, burst length, beat counter and sticky length-error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_idx      <= '0;
      r_len_q    <= '0;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|s_arvalid) begin
            r_grant <= w_win;
            r_idx   <= w_win_idx;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_len_q    <= m_arlen;
            r_beat_cnt <= '0;
          end else if (!w_sel_arvalid) begin
            r_grant <= '0;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
            if (m_rlast) begin
              r_grant <= '0;
              if (r_beat_cnt != {1'b0, r_len_q}) r_len_err <= 1'b1;
            end else if (r_beat_cnt == {1'b0, r_len_q}) begin
              r_len_err <= 1'b1;
            end
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  // Combinational AR/R steering toward and from the current owner only
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    s_rresp   = RESP_OKAY;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = 3'd0;
    m_arburst = BURST_FIXED;
    m_rready  = 1'b0;
    case (r_state)
      ST_ADDR: begin
        m_arvalid = w_sel_arvalid;
        m_araddr  = s_araddr[r_idx*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen   = s_arlen[r_idx*LEN_WIDTH +: LEN_WIDTH];
        m_arsize  = s_arsize[r_idx*3 +: 3];
        m_arburst = s_arburst[r_idx*2 +: 2];
        s_arready = r_grant & {NUM_MASTERS{m_arready}};
      end
      ST_DATA: begin
        // RREADY depends only on the owner's ready, never on RVALID/RLAST
        m_rready = |(s_rready & r_grant);
        s_rvalid = r_grant & {NUM_MASTERS{m_rvalid}};
        s_rdata  = m_rdata;
        s_rlast  = m_rlast;
        s_rresp  = m_rresp;
      end
      default: begin
        m_rready = 1'b0;
      end
    endcase
  end

  assign grant   = r_grant;
  assign len_err = r_len_err;

endmodule
